// File: rtl/systolic_pe_db.sv
// Weight-stationary systolic PE with NUM_BANKS weight banks: shadow banks load while the active bank computes.
// Saturating signed/unsigned MAC; weight, activation and psum paths each have 1-cycle latency with no backpressure.
module systolic_pe_db #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 24,
  parameter int NUM_BANKS = 2,
  parameter int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              signed_mode,
  input  logic              w_load,
  input  logic [BANK_W-1:0] w_bank_sel,
  input  logic [DATA_W-1:0] w_in,
  output logic [DATA_W-1:0] w_out,
  output logic              w_load_out,
  output logic [BANK_W-1:0] w_bank_sel_out,
  input  logic              bank_swap,
  output logic [BANK_W-1:0] active_bank,
  input  logic              act_valid_in,
  input  logic [DATA_W-1:0] act_in,
  output logic              act_valid_out,
  output logic [DATA_W-1:0] act_out,
  input  logic              psum_valid_in,
  input  logic [ACC_W-1:0]  psum_in,
  output logic              psum_valid_out,
  output logic [ACC_W-1:0]  psum_out,
  output logic              w_conflict
);

  generate
    if (ACC_W < 2 * DATA_W) begin : g_acc_w_check
      $error("systolic_pe_db: ACC_W must be at least 2*DATA_W");
    end
    if (NUM_BANKS < 2) begin : g_banks_check
      $error("systolic_pe_db: NUM_BANKS must be at least 2");
    end
  endgenerate

  logic [DATA_W-1:0] bank [NUM_BANKS];
  logic              sel_conflict;

  // Out-of-range selects can only occur when NUM_BANKS is not a power of two.
  assign sel_conflict = ({1'b0, w_bank_sel} >= (BANK_W + 1)'(NUM_BANKS)) ||
                        (w_bank_sel == active_bank);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BANKS; i++) bank[i] <= '0;
      w_out          <= '0;
      w_load_out     <= 1'b0;
      w_bank_sel_out <= '0;
      w_conflict     <= 1'b0;
      active_bank    <= '0;
    end else begin
      w_out          <= w_in;
      w_load_out     <= w_load;
      w_bank_sel_out <= w_bank_sel;
      if (w_load) begin
        if (sel_conflict) w_conflict <= 1'b1;
        else              bank[w_bank_sel] <= w_in;
      end
      if (bank_swap) begin
        if (active_bank == BANK_W'(NUM_BANKS - 1)) active_bank <= '0;
        else                                        active_bank <= active_bank + BANK_W'(1);
      end
    end
  end

  // Operands are extended to ACC_W+1 bits so one multiplier and adder serve both modes;
  // the true product and sum always fit in that width.
  logic [DATA_W-1:0] w_cur;
  logic [ACC_W:0]    w_x, a_x, prod, psum_x, sum;
  logic [ACC_W-1:0]  sat;

  assign w_cur = bank[active_bank];

  always_comb begin
    w_x    = {{(ACC_W + 1 - DATA_W){w_cur[DATA_W-1] & signed_mode}}, w_cur};
    a_x    = '0;
    if (act_valid_in)
      a_x  = {{(ACC_W + 1 - DATA_W){act_in[DATA_W-1] & signed_mode}}, act_in};
    prod   = w_x * a_x;
    psum_x = {psum_in[ACC_W-1] & signed_mode, psum_in};
    sum    = psum_x + prod;
    sat    = sum[ACC_W-1:0];
    if (signed_mode) begin
      if (sum[ACC_W] != sum[ACC_W-1])
        sat = sum[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}} : {1'b0, {(ACC_W - 1){1'b1}}};
    end else if (sum[ACC_W]) begin
      sat = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_valid_out  <= 1'b0;
      act_out        <= '0;
      psum_valid_out <= 1'b0;
      psum_out       <= '0;
    end else if (clear) begin
      act_valid_out  <= 1'b0;
      act_out        <= '0;
      psum_valid_out <= 1'b0;
      psum_out       <= '0;
    end else begin
      act_valid_out  <= act_valid_in;
      act_out        <= act_valid_in ? act_in : '0;
      psum_valid_out <= psum_valid_in;
      psum_out       <= sat;
    end
  end

endmodule
